// File: rtl/seg7_hex_sequencer.sv
// rtl/seg7_hex_sequencer.sv - hex value to 7-segment register-file write sequencer
// Converts a packed hex value into per-digit segment writes, skipping digits whose shadow already matches.
module seg7_hex_sequencer #(
  parameter int SEG7_NUM   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    s_clk,
  input  logic                    s_reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4*SEG7_NUM-1:0]   req_value,
  input  logic [SEG7_NUM-1:0]     req_dp,
  input  logic                    req_blank_lz,
  input  logic                    req_force,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    m_write,
  output logic [7:0]              m_writedata,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SEG7_NUM - 1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [4*SEG7_NUM-1:0]   r_value;
  logic [SEG7_NUM-1:0]     r_dp;
  logic                    r_blank_lz;
  logic                    r_force;
  logic [7:0]              r_shadow [SEG7_NUM];
  logic [SEG7_NUM-1:0]     r_sh_valid;

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'h0: f_seg = 7'h3F;
      4'h1: f_seg = 7'h06;
      4'h2: f_seg = 7'h5B;
      4'h3: f_seg = 7'h4F;
      4'h4: f_seg = 7'h66;
      4'h5: f_seg = 7'h6D;
      4'h6: f_seg = 7'h7D;
      4'h7: f_seg = 7'h07;
      4'h8: f_seg = 7'h7F;
      4'h9: f_seg = 7'h6F;
      4'hA: f_seg = 7'h77;
      4'hB: f_seg = 7'h7C;
      4'hC: f_seg = 7'h39;
      4'hD: f_seg = 7'h5E;
      4'hE: f_seg = 7'h79;
      default: f_seg = 7'h71;
    endcase
  endfunction

  // Digit 0 is encoded straight from the request inputs on the accept edge so
  // that its write lands in the first cycle after acceptance.
  logic                    w_is_idle;
  logic                    w_accept;
  logic                    w_emit;
  logic [ADDR_WIDTH-1:0]   w_dig;
  logic [4*SEG7_NUM-1:0]   w_val;
  logic [4*SEG7_NUM-1:0]   w_upper;
  logic [SEG7_NUM-1:0]     w_dp;
  logic                    w_blz;
  logic                    w_force;
  logic [3:0]              w_nib;
  logic                    w_blank;
  logic [7:0]              w_code;
  logic                    w_need;

  assign w_is_idle = (r_state == S_IDLE);
  assign w_accept  = w_is_idle && req_valid && req_ready;
  assign w_emit    = w_accept || ((r_state == S_SCAN) && (r_idx != LAST_IDX));
  assign w_dig     = w_is_idle ? '0 : ADDR_WIDTH'(r_idx + 1'b1);
  assign w_val     = w_is_idle ? req_value    : r_value;
  assign w_dp      = w_is_idle ? req_dp       : r_dp;
  assign w_blz     = w_is_idle ? req_blank_lz : r_blank_lz;
  assign w_force   = w_is_idle ? req_force    : r_force;
  assign w_nib     = w_val[{w_dig, 2'b00} +: 4];
  assign w_upper   = w_val >> {w_dig, 2'b00};
  assign w_blank   = w_blz && (w_dig != '0) && (w_upper == '0);
  assign w_code    = {w_dp[w_dig], (w_blank ? 7'h00 : f_seg(w_nib))};
  assign w_need    = w_force || !r_sh_valid[w_dig] || (w_code != r_shadow[w_dig]);

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_value     <= '0;
      r_dp        <= '0;
      r_blank_lz  <= 1'b0;
      r_force     <= 1'b0;
      r_sh_valid  <= '0;
      req_ready   <= 1'b1;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= 8'h00;
      done        <= 1'b0;
      for (int i = 0; i < SEG7_NUM; i++) r_shadow[i] <= 8'h00;
    end else begin
      m_write <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_value    <= req_value;
            r_dp       <= req_dp;
            r_blank_lz <= req_blank_lz;
            r_force    <= req_force;
            r_idx      <= '0;
            req_ready  <= 1'b0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_idx == LAST_IDX) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= w_dig;
          end
        end
        default: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
      if (w_emit && w_need) begin
        m_write             <= 1'b1;
        m_address           <= w_dig;
        m_writedata         <= w_code;
        r_shadow[w_dig]     <= w_code;
        r_sh_valid[w_dig]   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_hex_sequencer.sv
// tb/tb_seg7_hex_sequencer.sv - scoreboard bench for seg7_hex_sequencer
// Cycle k is the clock period ending at rising edge k; an accept at edge N puts digit i in cycle N+1+i.
module tb_seg7_hex_sequencer;

  logic        s_clk = 1'b0;
  logic        s_reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_value = '0;
  logic [7:0]  req_dp = '0;
  logic        req_blank_lz = 1'b0;
  logic        req_force = 1'b0;
  logic [2:0]  m_address;
  logic        m_write;
  logic [7:0]  m_writedata;
  logic        done;

  seg7_hex_sequencer #(.SEG7_NUM(8), .ADDR_WIDTH(3)) dut (
    .s_clk(s_clk), .s_reset_n(s_reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_dp(req_dp),
    .req_blank_lz(req_blank_lz), .req_force(req_force),
    .m_address(m_address), .m_write(m_write),
    .m_writedata(m_writedata), .done(done)
  );

  always #5 s_clk = ~s_clk;

  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] m_shadow [8];
  bit         m_sh_valid [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Reference: display what the digits should show, then write only what differs.
  task automatic model_push(input int n, input logic [31:0] v, input logic [7:0] dp,
                            input bit blz, input bit frc, input int limit);
    int msd;
    logic [3:0] nib;
    logic [7:0] code;
    exp_t e;
    msd = 0;
    for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) msd = i;
    for (int i = 0; i < limit; i++) begin
      nib  = 4'((v >> (4 * i)) & 32'hF);
      code = (blz && i > msd) ? 8'h00 : seg_tbl[nib];
      if (dp[i]) code = code | 8'h80;
      if (frc || !m_sh_valid[i] || m_shadow[i] != code) begin
        e.is_done = 1'b0; e.cyc = n + 1 + i; e.addr = 3'(i); e.data = code;
        exp_q.push_back(e);
        m_shadow[i]   = code;
        m_sh_valid[i] = 1'b1;
      end
    end
    if (limit == 8) begin
      e.is_done = 1'b1; e.cyc = n + 9; e.addr = 3'd0; e.data = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge s_clk) begin
    exp_t e;
    int cur;
    if (s_reset_n && (m_write || done)) begin
      cur = cyc + 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got write=%0d done=%0d addr=%0d data=%h in cycle %0d, required nothing",
                 m_write, done, m_address, m_writedata, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done != done || e.is_done == m_write || e.cyc != cur ||
            (!e.is_done && (e.addr != m_address || e.data != m_writedata))) begin
          errors++;
          $display("FAIL scoreboard: got write=%0d done=%0d addr=%0d data=%h cycle=%0d, required done=%0d addr=%0d data=%h cycle=%0d",
                   m_write, done, m_address, m_writedata, cur, e.is_done, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [7:0] dp, input bit blz,
                      input bit frc, input bit hold, input bit abort);
    int n;
    int bound;
    @(negedge s_clk);
    req_value = v; req_dp = dp; req_blank_lz = blz; req_force = frc; req_valid = 1'b1;
    bound = 0;
    while (!req_ready && bound < 40) begin @(negedge s_clk); bound++; end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    n = cyc + 1;
    model_push(n, v, dp, blz, frc, abort ? 3 : 8);
    @(posedge s_clk); #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_value = $urandom; req_dp = 8'($urandom); req_blank_lz = 1'($urandom); req_force = 1'($urandom);
    end
    if (abort) begin
      while (cyc < n + 3) begin @(posedge s_clk); #1; end
      check("abort_digit3_write", {31'd0, m_write}, 32'd1);
      #1 s_reset_n = 1'b0;
      #1;
      check("async_reset_write", {31'd0, m_write}, 32'd0);
      check("async_reset_ready", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 8; i++) m_sh_valid[i] = 1'b0;
      repeat (2) @(negedge s_clk);
      s_reset_n = 1'b1;
      req_valid = 1'b0;
      #1 check("ready_after_release", {31'd0, req_ready}, 32'd1);
      return;
    end
    bound = 0;
    @(negedge s_clk);
    while (!req_ready && bound < 40) begin @(negedge s_clk); bound++; end
    req_valid = 1'b0;
    check("ready_return_cycle", 32'(cyc + 1), 32'(n + 10));
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] prev;
    for (int i = 0; i < 8; i++) begin m_shadow[i] = 8'h00; m_sh_valid[i] = 1'b0; end
    repeat (3) @(negedge s_clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_write", {31'd0, m_write}, 32'd0);
    check("reset_addr", {29'd0, m_address}, 32'd0);
    check("reset_data", {24'd0, m_writedata}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    s_reset_n = 1'b1;

    send(32'h0000_0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(32'h1234_ABCD, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h1234_ABCD, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h1234_ABCD, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h00F0_0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(32'h8765_4321, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    prev = 32'h0;
    for (int k = 0; k < 40; k++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v = v >> (4 * $urandom_range(1, 8));
        1: v = prev;
        default: ;
      endcase
      send(v, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
           1'($urandom), ($urandom_range(0, 4) == 0), 1'b0, 1'b0);
      prev = v;
    end

    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge s_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
